// File: rtl/bullet_frame_scheduler.sv
// Bullet frame scheduler: once per video frame, during vertical blank, it
// walks the bullet engine through its clean, insert and move passes. It also
// collects fire presses from the shooters and, each frame, inserts the bullet
// of at most one of them, chosen round-robin.
module bullet_frame_scheduler #(
    parameter int NUM_SHOOTERS = 2,
    parameter int V_ACTIVE     = 600,
    parameter int WATCHDOG     = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [10:0]             display_row,
    input  logic [11:0]             display_col,
    input  logic [NUM_SHOOTERS-1:0] fire_req,
    input  logic                    engine_done,
    output logic                    calc,
    output logic [1:0]              phase,
    output logic                    phase_start,
    output logic [NUM_SHOOTERS-1:0] grant,
    output logic                    fire_accept,
    output logic                    overrun,
    output logic [7:0]              frame_count
);

    localparam int IDX_W = (NUM_SHOOTERS > 1) ? $clog2(NUM_SHOOTERS) : 1;
    localparam int WD_W  = $clog2(WATCHDOG + 1);

    localparam logic [10:0]      BLANK_ROW = 11'(V_ACTIVE);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WATCHDOG - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SHOOTERS - 1);

    localparam logic [1:0] PH_CLEAN  = 2'd0;
    localparam logic [1:0] PH_INSERT = 2'd1;
    localparam logic [1:0] PH_MOVE   = 2'd2;
    localparam logic [1:0] PH_IDLE   = 2'd3;

    typedef enum logic [2:0] {IDLE, CLEAN, INSERT, MOVE, FINISH} state_t;

    state_t                  state;
    logic [NUM_SHOOTERS-1:0] fire_prev;
    logic [NUM_SHOOTERS-1:0] pending;
    logic [NUM_SHOOTERS-1:0] fire_rise;
    logic [NUM_SHOOTERS-1:0] clear_mask;
    logic [NUM_SHOOTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]        pointer;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        upper_idx;
    logic [IDX_W-1:0]        lower_idx;
    logic [IDX_W-1:0]        next_pointer;
    logic                    upper_found;
    logic                    lower_found;
    logic [WD_W-1:0]         wd_count;
    logic                    in_phase;
    logic                    blank_start;
    logic                    row_abort;
    logic                    wd_abort;
    logic                    accept_now;

    assign fire_rise    = fire_req & ~fire_prev;
    assign in_phase     = (state == CLEAN) || (state == INSERT) || (state == MOVE);
    assign blank_start  = (display_row == BLANK_ROW) && (display_col == '0);
    assign row_abort    = in_phase && (display_row == '0);
    assign wd_abort     = in_phase && !engine_done && (wd_count == WD_LAST);
    assign accept_now   = (state == INSERT) && engine_done && !row_abort;
    assign clear_mask   = accept_now ? grant : '0;
    assign next_pointer = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    // Round-robin pick: the first pending shooter at or above the pointer,
    // otherwise wrap around to the lowest pending shooter.
    always_comb begin
        upper_found = 1'b0;
        lower_found = 1'b0;
        upper_idx   = '0;
        lower_idx   = '0;
        for (int j = 0; j < NUM_SHOOTERS; j++) begin
            if (pending[j]) begin
                if (!lower_found) begin
                    lower_found = 1'b1;
                    lower_idx   = IDX_W'(j);
                end
                if (!upper_found && (IDX_W'(j) >= pointer)) begin
                    upper_found = 1'b1;
                    upper_idx   = IDX_W'(j);
                end
            end
        end
        pick_idx = upper_found ? upper_idx : lower_idx;
        for (int j = 0; j < NUM_SHOOTERS; j++) begin
            pick_onehot[j] = (IDX_W'(j) == pick_idx);
        end
    end

    // Fire capture: a rising edge latches a pending request. When the same
    // edge arrives in the cycle the grant clears that shooter's bit, the new
    // press wins, so a quick re-fire is never lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_prev <= '0;
            pending   <= '0;
        end else begin
            fire_prev <= fire_req;
            pending   <= (pending & ~clear_mask) | fire_rise;
        end
    end

    // Frame sequencer: the blank start opens the update window, each
    // engine_done advances one pass, and the next active area closes it.
    // A stalled pass or a window overlapping the active area aborts to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            calc        <= 1'b0;
            phase       <= PH_IDLE;
            phase_start <= 1'b0;
            grant       <= '0;
            grant_idx   <= '0;
            fire_accept <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 8'd0;
            pointer     <= '0;
            wd_count    <= '0;
        end else begin
            phase_start <= 1'b0;
            fire_accept <= 1'b0;
            if (in_phase) begin
                wd_count <= wd_count + 1'b1;
            end
            if (row_abort || wd_abort) begin
                state   <= IDLE;
                overrun <= 1'b1;
                grant   <= '0;
                calc    <= 1'b0;
                phase   <= PH_IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (blank_start) begin
                            state       <= CLEAN;
                            calc        <= 1'b1;
                            phase       <= PH_CLEAN;
                            phase_start <= 1'b1;
                            wd_count    <= '0;
                        end
                    end
                    CLEAN: begin
                        if (engine_done) begin
                            phase_start <= 1'b1;
                            wd_count    <= '0;
                            if (lower_found) begin
                                state     <= INSERT;
                                phase     <= PH_INSERT;
                                grant     <= pick_onehot;
                                grant_idx <= pick_idx;
                            end else begin
                                state <= MOVE;
                                phase <= PH_MOVE;
                            end
                        end
                    end
                    INSERT: begin
                        if (engine_done) begin
                            state       <= MOVE;
                            phase       <= PH_MOVE;
                            phase_start <= 1'b1;
                            wd_count    <= '0;
                            fire_accept <= 1'b1;
                            pointer     <= next_pointer;
                            grant       <= '0;
                        end
                    end
                    MOVE: begin
                        if (engine_done) begin
                            state       <= FINISH;
                            phase       <= PH_IDLE;
                            frame_count <= frame_count + 8'd1;
                        end
                    end
                    FINISH: begin
                        if (display_row == '0) begin
                            state <= IDLE;
                            calc  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        calc  <= 1'b0;
                        phase <= PH_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bullet_frame_scheduler.sv
// Directed bench for bullet_frame_scheduler with two shooters. Inputs are
// driven and outputs sampled 1 ns after each rising clock edge.
module tb_bullet_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] display_row;
    logic [11:0] display_col;
    logic [1:0]  fire_req;
    logic        engine_done;
    logic        calc;
    logic [1:0]  phase;
    logic        phase_start;
    logic [1:0]  grant;
    logic        fire_accept;
    logic        overrun;
    logic [7:0]  frame_count;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;

    bullet_frame_scheduler #(
        .NUM_SHOOTERS(2),
        .V_ACTIVE(600),
        .WATCHDOG(4096)
    ) dut (
        .clock(clock),
        .reset(reset),
        .display_row(display_row),
        .display_col(display_col),
        .fire_req(fire_req),
        .engine_done(engine_done),
        .calc(calc),
        .phase(phase),
        .phase_start(phase_start),
        .grant(grant),
        .fire_accept(fire_accept),
        .overrun(overrun),
        .frame_count(frame_count)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        display_row = 11'd600;
        display_col = 12'd0;
        tick(1);
        display_row = 11'd601;
        display_col = 12'd1;
    endtask

    task automatic pulse_done();
        engine_done = 1'b1;
        tick(1);
        engine_done = 1'b0;
    endtask

    task automatic end_window();
        display_row = 11'd0;
        tick(1);
        display_row = 11'd100;
        display_col = 12'd5;
    endtask

    task automatic run_frame(output logic [1:0] g, output int acc);
        start_frame();
        tick(2);
        pulse_done();
        g   = grant;
        acc = 0;
        if (phase == 2'd1) begin
            tick(1);
            pulse_done();
            acc += int'(fire_accept);
        end
        tick(1);
        acc += int'(fire_accept);
        pulse_done();
        end_window();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if ({calc, phase, phase_start, grant, fire_accept, overrun, frame_count} !==
            {1'b0, 2'd3, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got calc=%0b phase=%0d ps=%0b grant=%b acc=%0b ovr=%0b fc=%0d want 0,3,0,00,0,0,0",
                     calc, phase, phase_start, grant, fire_accept, overrun, frame_count);
        end
        reset = 1'b1;
        tick(1);
        start_frame();
        pulse_done();
        checks++;
        if (phase !== 2'd2) begin
            errors++;
            $display("[TB] FAIL reset_reach_move: got phase=%0d want 2", phase);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({calc, phase, grant, phase_start} !== {1'b0, 2'd3, 2'b00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async: got calc=%0b phase=%0d grant=%b ps=%0b want 0,3,00,0",
                     calc, phase, grant, phase_start);
        end
        tick(1);
        reset = 1'b1;
        tick(1);
        start_frame();
        checks++;
        if ({calc, phase, phase_start} !== {1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL trigger_clean: got calc=%0b phase=%0d ps=%0b want 1,0,1", calc, phase, phase_start);
        end
        tick(1);
        checks++;
        if ({calc, phase, phase_start} !== {1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL trigger_single_pulse: got calc=%0b phase=%0d ps=%0b want 1,0,0", calc, phase, phase_start);
        end
    endtask

    task automatic test_no_fire();
        tick(10);
        pulse_done();
        checks++;
        if ({phase, phase_start, grant, fire_accept, calc} !== {2'd2, 1'b1, 2'b00, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL nofire_skip_insert: got phase=%0d ps=%0b grant=%b acc=%0b calc=%0b want 2,1,00,0,1",
                     phase, phase_start, grant, fire_accept, calc);
        end
        tick(1);
        checks++;
        if (phase_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nofire_ps_drop: got %0b want 0", phase_start);
        end
        pulse_done();
        exp_frames = 1;
        checks++;
        if ({phase, calc, frame_count} !== {2'd3, 1'b1, 8'(exp_frames)}) begin
            errors++;
            $display("[TB] FAIL nofire_finish: got phase=%0d calc=%0b fc=%0d want 3,1,%0d", phase, calc, frame_count, exp_frames);
        end
        pulse_done();
        display_row = 11'd600;
        display_col = 12'd0;
        tick(1);
        display_row = 11'd601;
        checks++;
        if ({phase, calc, phase_start, frame_count} !== {2'd3, 1'b1, 1'b0, 8'(exp_frames)}) begin
            errors++;
            $display("[TB] FAIL finish_ignores_inputs: got phase=%0d calc=%0b ps=%0b fc=%0d want 3,1,0,%0d",
                     phase, calc, phase_start, frame_count, exp_frames);
        end
        end_window();
        checks++;
        if ({calc, phase} !== {1'b0, 2'd3}) begin
            errors++;
            $display("[TB] FAIL window_close: got calc=%0b phase=%0d want 0,3", calc, phase);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        int         acc;
        logic [1:0] want_g [3] = '{2'b01, 2'b10, 2'b00};
        int         want_a [3] = '{1, 1, 0};
        fire_req = 2'b11;
        tick(1);
        fire_req = 2'b00;
        tick(1);
        for (int f = 0; f < 3; f++) begin
            run_frame(g, acc);
            exp_frames++;
            checks++;
            if (g !== want_g[f] || acc != want_a[f] || frame_count !== 8'(exp_frames)) begin
                errors++;
                $display("[TB] FAIL round_robin_frame%0d: got grant=%b accepts=%0d fc=%0d want %b,%0d,%0d",
                         f + 1, g, acc, frame_count, want_g[f], want_a[f], exp_frames);
            end
        end
    endtask

    task automatic test_held_fire();
        logic [1:0] g;
        logic [1:0] first_g;
        int         acc;
        int         total_acc = 0;
        int         grants = 0;
        fire_req = 2'b01;
        tick(1);
        for (int f = 0; f < 3; f++) begin
            run_frame(g, acc);
            if (f == 0) first_g = g;
            total_acc += acc;
            if (g != 2'b00) grants++;
            exp_frames++;
        end
        fire_req = 2'b00;
        tick(1);
        checks++;
        if (first_g !== 2'b01 || grants != 1 || total_acc != 1) begin
            errors++;
            $display("[TB] FAIL held_fire: got first=%b grants=%0d accepts=%0d want 01,1,1", first_g, grants, total_acc);
        end
        checks++;
        if (frame_count !== 8'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL held_frame_count: got %0d want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_same_cycle_refire();
        logic [1:0] g;
        int         acc;
        fire_req = 2'b01;
        tick(1);
        start_frame();
        tick(2);
        pulse_done();
        checks++;
        if ({phase, grant} !== {2'd1, 2'b01}) begin
            errors++;
            $display("[TB] FAIL refire_insert: got phase=%0d grant=%b want 1,01", phase, grant);
        end
        fire_req = 2'b00;
        tick(1);
        fire_req = 2'b01;
        engine_done = 1'b1;
        tick(1);
        engine_done = 1'b0;
        checks++;
        if ({fire_accept, phase, phase_start, grant} !== {1'b1, 2'd2, 1'b1, 2'b00}) begin
            errors++;
            $display("[TB] FAIL refire_accept: got acc=%0b phase=%0d ps=%0b grant=%b want 1,2,1,00",
                     fire_accept, phase, phase_start, grant);
        end
        tick(1);
        pulse_done();
        end_window();
        exp_frames++;
        run_frame(g, acc);
        exp_frames++;
        checks++;
        if (g !== 2'b01 || acc != 1) begin
            errors++;
            $display("[TB] FAIL refire_next_frame: got grant=%b accepts=%0d want 01,1", g, acc);
        end
        fire_req = 2'b00;
        tick(1);
    endtask

    task automatic test_watchdog();
        logic [1:0] g;
        int         acc;
        start_frame();
        tick(4095);
        checks++;
        if ({overrun, calc, phase} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("[TB] FAIL wd_not_yet: got ovr=%0b calc=%0b phase=%0d want 0,1,0", overrun, calc, phase);
        end
        tick(1);
        checks++;
        if ({overrun, calc, phase, grant, phase_start, frame_count} !==
            {1'b1, 1'b0, 2'd3, 2'b00, 1'b0, 8'(exp_frames)}) begin
            errors++;
            $display("[TB] FAIL wd_abort: got ovr=%0b calc=%0b phase=%0d grant=%b ps=%0b fc=%0d want 1,0,3,00,0,%0d",
                     overrun, calc, phase, grant, phase_start, frame_count, exp_frames);
        end
        run_frame(g, acc);
        exp_frames++;
        checks++;
        if ({overrun, frame_count, calc} !== {1'b1, 8'(exp_frames), 1'b0} || acc != 0) begin
            errors++;
            $display("[TB] FAIL wd_sticky: got ovr=%0b fc=%0d calc=%0b accepts=%0d want 1,%0d,0,0",
                     overrun, frame_count, calc, acc, exp_frames);
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({overrun, frame_count} !== {1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL wd_reset_clears: got ovr=%0b fc=%0d want 0,0", overrun, frame_count);
        end
        tick(1);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        reset       = 1'b0;
        display_row = 11'd100;
        display_col = 12'd5;
        fire_req    = 2'b00;
        engine_done = 1'b0;
        test_reset();
        test_no_fire();
        test_round_robin();
        test_held_fire();
        test_same_cycle_refire();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bullet_frame_scheduler.md
Name: bullet_frame_scheduler

Overview:
- Sequences the bullet update engine once per video frame: raises calc during vertical blank and steps the engine through its clean, insert and move passes with a start/done handshake.
- Arbitrates fire requests from several shooters round-robin and grants at most one bullet insertion per frame.
- Sits between the VGA timing counters, the player input logic and the bullets block.

Parameters:
NUM_SHOOTERS, 2, number of fire requesters (1..8)
V_ACTIVE, 600, first display_row value of vertical blank
WATCHDOG, 4096, max clock cycles allowed per phase before abort

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
display_row  input  11  current scan row
display_col  input  12  current scan column
fire_req  input  NUM_SHOOTERS  level fire request per shooter; active-high
engine_done  input  1  one-cycle pulse from the engine: current phase finished
calc  output  1  high for the whole update window
phase  output  2  0=clean, 1=insert, 2=move, 3=idle
phase_start  output  1  one-cycle pulse on entry to clean, insert or move
grant  output  NUM_SHOOTERS  one-hot; the shooter whose bullet is inserted this frame
fire_accept  output  1  one-cycle pulse when the insert phase completes with a grant
overrun  output  1  sticky error flag
frame_count  output  8  count of completed update windows; wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - Outputs: calc=0, phase=3, phase_start=0, grant=0, fire_accept=0, overrun=0, frame_count=0.
  - Pending bits, edge registers and round-robin pointer clear (pointer=0).
  - On release, everything resumes on the first clock edge.
- FSM states: IDLE, CLEAN, INSERT, MOVE, FINISH. All outputs are registered.
- IDLE -> CLEAN:
  - Trigger: display_row==V_ACTIVE and display_col==0, sampled on a clock edge.
  - Next cycle: calc=1, phase=0, phase_start=1 for exactly one cycle.
- CLEAN -> INSERT: on engine_done.
  - If any pending bit is set: phase=1, phase_start pulses, grant = first pending shooter at or after the round-robin pointer, scanning upward and wrapping.
  - If no pending bit is set: go directly to MOVE. phase=2, one phase_start pulse, grant stays 0, no insert pulse.
- INSERT -> MOVE: on engine_done.
  - fire_accept pulses once.
  - The granted shooter's pending bit clears.
  - Pointer = granted index + 1, mod NUM_SHOOTERS.
  - grant returns to 0; phase=2; phase_start pulses.
- MOVE -> FINISH: on engine_done. frame_count increments; calc stays 1; phase=3.
- FINISH -> IDLE: when display_row==0, i.e. the active area starts. calc drops to 0 on that edge.
- Fire capture:
  - Each fire_req bit goes through a 1-flop edge register.
  - A rising edge sets that shooter's pending bit.
  - Held levels set the bit only once per press.
- Simultaneous clear and set: if the rising edge arrives in the same cycle the granted shooter's bit clears, the bit stays set (the new request wins).
- Watchdog:
  - A per-phase counter resets on every phase_start.
  - Abort if it reaches WATCHDOG without engine_done, or if display_row==0 arrives before FINISH.
  - On abort: overrun=1 (sticky until reset), grant=0, calc=0, phase=3, FSM returns to IDLE.
  - Pending bits are kept; no fire_accept, no frame_count increment.
- engine_done while in IDLE or FINISH is ignored.
- A blank-start trigger while not in IDLE is ignored.
- phase_start never pulses in the same cycle as engine_done is consumed from the previous phase. The pulse comes on the next cycle, together with the new phase value.
- calc is constant 1 from the CLEAN entry through FINISH, with no glitch between phases.

Test Plan:
- Reset then frame trigger: pulse reset=0 mid-MOVE -> calc=0, phase=3, grant=0 immediately. Then drive row=600/col=0 -> next cycle calc=1, phase=0, one phase_start.
- No fire: engine_done after 10 cycles in CLEAN -> phase goes 0->2 directly, grant=0, no fire_accept. engine_done in MOVE -> frame_count 0->1. Row=0 -> calc=0.
- Round-robin, NUM_SHOOTERS=2, both fire_req rising before the frame:
  - Frame 1: grant=01, fire_accept pulses.
  - Frame 2: grant=10.
  - Frame 3: no grant.
- Held fire: fire_req[0] held high across 3 frames -> exactly one grant and one fire_accept.
- Same-cycle re-fire: fire_req[0] drops and rises so its rising edge coincides with the INSERT engine_done -> pending[0] stays 1 and the next frame grants shooter 0 again.
- Watchdog: engine_done withheld in CLEAN for 4096 cycles -> overrun=1, calc=0, phase=3, frame_count unchanged. overrun stays 1 through the next normal frame until reset.
